// File: rtl/bcd_updown_counter_mux.sv
// -----------------------------------------------------------------------------
// bcd_updown_counter_mux
//
// Multi-digit BCD up/down counter with a multiplexed seven-segment display
// driver. The count changes on rising edges of `pulse`; clear and load are
// synchronous, and clear beats load, which beats a count event. The display
// scans one digit per REFRESH_DIV clocks and runs independently of the counter.
//
// Parameters
//   NUM_DIGITS  : number of BCD digits / display positions (2..8)
//   REFRESH_DIV : clk cycles each digit stays selected (>= 2)
//   BLANK_LZ    : 1 = blank leading zeros (digit 0 always shown)
//
// Ports
//   clk                  : clock, all state changes on its rising edge
//   rst                  : synchronous active-high reset
//   pulse                : count request, rising edge detected internally
//   up_down              : 1 = count up, 0 = count down
//   clear                : synchronous clear of the count
//   load                 : synchronous load of load_value (digits > 9 clamp to 9)
//   load_value           : BCD load value, digit 0 in bits [3:0]
//   count_bcd            : registered BCD count, digit 0 least significant
//   wrap                 : one-cycle pulse on all-9s -> all-0s or all-0s -> all-9s
//   seven_segment_data   : active-low {dp,g,f,e,d,c,b,a}
//   seven_segment_enable : active-low one-hot digit select
// -----------------------------------------------------------------------------
module bcd_updown_counter_mux #(
    parameter int NUM_DIGITS  = 4,
    parameter int REFRESH_DIV = 50000,
    parameter int BLANK_LZ    = 0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    pulse,
    input  logic                    up_down,
    input  logic                    clear,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] load_value,
    output logic [4*NUM_DIGITS-1:0] count_bcd,
    output logic                    wrap,
    output logic [7:0]              seven_segment_data,
    output logic [NUM_DIGITS-1:0]   seven_segment_enable
);

    localparam int CNT_W = $clog2(REFRESH_DIV);
    localparam int IDX_W = $clog2(NUM_DIGITS);
    localparam logic [CNT_W-1:0] REFRESH_LAST = CNT_W'(REFRESH_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST     = IDX_W'(NUM_DIGITS - 1);

    logic [4*NUM_DIGITS-1:0] count_q, count_d;
    logic                    wrap_q, wrap_d;
    logic                    pulse_q;
    logic                    count_event;
    logic [CNT_W-1:0]        refresh_q, refresh_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [NUM_DIGITS-1:0]   seg_en_q, seg_en_d;
    logic [7:0]              seg_data_q, seg_data_d;

    // Active-low segment patterns, dp always off.
    function automatic logic [7:0] seg_encode(input logic [3:0] digit);
        case (digit)
            4'd0:    seg_encode = 8'hC0;
            4'd1:    seg_encode = 8'hF9;
            4'd2:    seg_encode = 8'hA4;
            4'd3:    seg_encode = 8'hB0;
            4'd4:    seg_encode = 8'h99;
            4'd5:    seg_encode = 8'h92;
            4'd6:    seg_encode = 8'h82;
            4'd7:    seg_encode = 8'hF8;
            4'd8:    seg_encode = 8'h80;
            4'd9:    seg_encode = 8'h90;
            default: seg_encode = 8'hFF;
        endcase
    endfunction

    assign count_event = pulse & ~pulse_q;

    // Counter next state: clear > load > count event.
    always_comb begin : count_next
        logic       carry;
        logic [3:0] dig;
        // NOTE: every variable gets a default before any branch so no path
        // leaves it unassigned, which would otherwise infer a latch.
        count_d = count_q;
        wrap_d  = 1'b0;
        carry   = 1'b1;
        dig     = 4'd0;
        if (clear) begin
            count_d = '0;
        end else if (load) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                dig = load_value[4*i +: 4];
                count_d[4*i +: 4] = (dig > 4'd9) ? 4'd9 : dig;
            end
        end else if (count_event) begin
            // Decimal ripple: carry (up) or borrow (down) moves upward only
            // while digits roll over; a carry out of the top digit is a wrap.
            for (int i = 0; i < NUM_DIGITS; i++) begin
                dig = count_q[4*i +: 4];
                if (carry) begin
                    if (up_down) begin
                        if (dig == 4'd9) begin
                            count_d[4*i +: 4] = 4'd0;
                        end else begin
                            count_d[4*i +: 4] = dig + 4'd1;
                            carry = 1'b0;
                        end
                    end else begin
                        if (dig == 4'd0) begin
                            count_d[4*i +: 4] = 4'd9;
                        end else begin
                            count_d[4*i +: 4] = dig - 4'd1;
                            carry = 1'b0;
                        end
                    end
                end
            end
            wrap_d = carry;
        end
    end

    // Display scan next state.
    always_comb begin : display_next
        logic       zero_above;
        logic [3:0] cur_digit;
        logic       blank_cur;
        zero_above = 1'b1;
        cur_digit  = 4'd0;
        blank_cur  = 1'b0;
        // Walk from the top digit down so zero_above means "this digit and
        // every digit above it are zero" when the selected digit is reached.
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            zero_above = zero_above & (count_q[4*i +: 4] == 4'd0);
            if (idx_q == IDX_W'(i)) begin
                cur_digit = count_q[4*i +: 4];
                blank_cur = (BLANK_LZ != 0) && (i != 0) && zero_above;
            end
        end
        seg_en_d   = ~(NUM_DIGITS'(1) << idx_q);
        seg_data_d = blank_cur ? 8'hFF : seg_encode(cur_digit);

        if (refresh_q == REFRESH_LAST) begin
            refresh_d = '0;
            idx_d     = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
        end else begin
            refresh_d = refresh_q + CNT_W'(1);
            idx_d     = idx_q;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q    <= '0;
            wrap_q     <= 1'b0;
            // Held high so a pulse already high at reset release is not an edge.
            pulse_q    <= 1'b1;
            refresh_q  <= '0;
            idx_q      <= '0;
            seg_en_q   <= '1;
            seg_data_q <= 8'hFF;
        end else begin
            count_q    <= count_d;
            wrap_q     <= wrap_d;
            pulse_q    <= pulse;
            refresh_q  <= refresh_d;
            idx_q      <= idx_d;
            seg_en_q   <= seg_en_d;
            seg_data_q <= seg_data_d;
        end
    end

    assign count_bcd            = count_q;
    assign wrap                 = wrap_q;
    assign seven_segment_data   = seg_data_q;
    assign seven_segment_enable = seg_en_q;

endmodule

// File: tb/tb_bcd_updown_counter_mux.sv
// -----------------------------------------------------------------------------
// tb_bcd_updown_counter_mux
//
// Self-checking bench for bcd_updown_counter_mux (NUM_DIGITS=4, REFRESH_DIV=4).
// Two instances share all inputs: one without and one with leading-zero
// blanking. A behavioural model holds the count as a plain integer and derives
// the display from a cycle counter; a compare loop checks both instances
// against it every cycle, and directed steps add literal expectations.
// -----------------------------------------------------------------------------
module tb_bcd_updown_counter_mux;

    localparam int ND   = 4;
    localparam int DIV  = 4;
    localparam int MAXV = 9999;

    logic        clk = 1'b0;
    logic        rst;
    logic        pulse;
    logic        up_down;
    logic        clear;
    logic        load;
    logic [15:0] load_value;

    logic [15:0] count0, count1;
    logic        wrap0, wrap1;
    logic [7:0]  data0, data1;
    logic [3:0]  en0, en1;

    always #5 clk = ~clk;

    bcd_updown_counter_mux #(.NUM_DIGITS(ND), .REFRESH_DIV(DIV), .BLANK_LZ(0)) dut0 (
        .clk                  (clk),
        .rst                  (rst),
        .pulse                (pulse),
        .up_down              (up_down),
        .clear                (clear),
        .load                 (load),
        .load_value           (load_value),
        .count_bcd            (count0),
        .wrap                 (wrap0),
        .seven_segment_data   (data0),
        .seven_segment_enable (en0)
    );

    bcd_updown_counter_mux #(.NUM_DIGITS(ND), .REFRESH_DIV(DIV), .BLANK_LZ(1)) dut1 (
        .clk                  (clk),
        .rst                  (rst),
        .pulse                (pulse),
        .up_down              (up_down),
        .clear                (clear),
        .load                 (load),
        .load_value           (load_value),
        .count_bcd            (count1),
        .wrap                 (wrap1),
        .seven_segment_data   (data1),
        .seven_segment_enable (en1)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int wrap_cnt = 0;

    // ---------------- behavioural model ----------------
    bit         m_valid = 1'b0;
    int         m_count;
    bit         m_wrap;
    bit         m_prev;
    int         m_k;
    logic [3:0] m_en;
    logic [7:0] m_data0, m_data1;

    logic [3:0] exp_en [4] = '{4'hE, 4'hD, 4'hB, 4'h7};
    logic [7:0] exp_d0 [4] = '{8'hA4, 8'h99, 8'hC0, 8'hC0};
    logic [7:0] exp_d1 [4] = '{8'hA4, 8'h99, 8'hFF, 8'hFF};

    function automatic int pow10(input int e);
        int r = 1;
        for (int i = 0; i < e; i++) r = r * 10;
        return r;
    endfunction

    function automatic logic [7:0] seg_of(input int d);
        case (d)
            0: return 8'hC0;  1: return 8'hF9;  2: return 8'hA4;  3: return 8'hB0;
            4: return 8'h99;  5: return 8'h92;  6: return 8'h82;  7: return 8'hF8;
            8: return 8'h80;  default: return 8'h90;
        endcase
    endfunction

    function automatic logic [15:0] to_bcd(input int v);
        logic [15:0] r = '0;
        for (int i = 0; i < ND; i++) r[4*i +: 4] = 4'((v / pow10(i)) % 10);
        return r;
    endfunction

    function automatic int from_load(input logic [15:0] v);
        int sum = 0;
        int d;
        for (int i = 0; i < ND; i++) begin
            d = int'(v[4*i +: 4]);
            if (d > 9) d = 9;
            sum = sum + d * pow10(i);
        end
        return sum;
    endfunction

    always @(posedge clk) begin
        int idx;
        bit ev;
        if (rst) begin
            m_valid = 1'b1;
            m_count = 0;
            m_wrap  = 1'b0;
            m_prev  = 1'b1;
            m_k     = 0;
            m_en    = 4'hF;
            m_data0 = 8'hFF;
            m_data1 = 8'hFF;
        end else if (m_valid) begin
            // Display reflects the state held before this edge.
            idx     = (m_k / DIV) % ND;
            m_en    = ~(4'b0001 << idx);
            m_data0 = seg_of((m_count / pow10(idx)) % 10);
            m_data1 = (idx != 0 && (m_count / pow10(idx)) == 0) ? 8'hFF : m_data0;
            m_k     = m_k + 1;

            ev     = pulse && !m_prev;
            m_prev = pulse;
            m_wrap = 1'b0;
            if (clear) begin
                m_count = 0;
            end else if (load) begin
                m_count = from_load(load_value);
            end else if (ev) begin
                if (up_down) begin
                    m_wrap  = (m_count == MAXV);
                    m_count = (m_count + 1) % (MAXV + 1);
                end else begin
                    m_wrap  = (m_count == 0);
                    m_count = (m_count == 0) ? MAXV : m_count - 1;
                end
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        else n_pass++;
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_once(input logic dir);
        up_down = dir;
        pulse   = 1'b1;
        tick(2);
        pulse   = 1'b0;
        tick(2);
    endtask

    task automatic do_load(input logic [15:0] v);
        load_value = v;
        load       = 1'b1;
        tick(1);
        load       = 1'b0;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        tick(1);
        clear = 1'b0;
    endtask

    // ---------------- stimulus and checking ----------------
    initial begin
        int w0;
        int n;
        rst        = 1'b1;
        pulse      = 1'b0;
        up_down    = 1'b1;
        clear      = 1'b0;
        load       = 1'b0;
        load_value = '0;

        fork
            forever begin
                @(negedge clk);
                if (m_valid) begin
                    check("cmp_count",    32'(count0), 32'(to_bcd(m_count)));
                    check("cmp_wrap",     32'(wrap0),  32'(m_wrap));
                    check("cmp_enable",   32'(en0),    32'(m_en));
                    check("cmp_data",     32'(data0),  32'(m_data0));
                    check("cmp_count_lz", 32'(count1), 32'(to_bcd(m_count)));
                    check("cmp_enable_lz",32'(en1),    32'(m_en));
                    check("cmp_data_lz",  32'(data1),  32'(m_data1));
                    if (wrap0) wrap_cnt++;
                end
            end
        join_none

        // Reset state.
        tick(2);
        check("rst_count",  32'(count0), 32'h0);
        check("rst_wrap",   32'(wrap0),  32'h0);
        check("rst_enable", 32'(en0),    32'hF);
        check("rst_data",   32'(data0),  32'hFF);
        rst = 1'b0;
        tick(1);
        check("first_enable", 32'(en0), 32'hE);

        // Twelve up pulses.
        w0 = wrap_cnt;
        for (int i = 0; i < 12; i++) pulse_once(1'b1);
        check("up12_count", 32'(count0), 32'h0012);
        check("up12_nowrap", 32'(wrap_cnt - w0), 32'd0);

        // Up wrap.
        do_load(16'h9998);
        check("load_9998", 32'(count0), 32'h9998);
        pulse_once(1'b1);
        check("up_9999", 32'(count0), 32'h9999);
        w0 = wrap_cnt;
        up_down = 1'b1;
        pulse   = 1'b1;
        tick(1);
        check("upwrap_count", 32'(count0), 32'h0000);
        check("upwrap_wrap",  32'(wrap0),  32'h1);
        tick(1);
        check("upwrap_wrap_end", 32'(wrap0), 32'h0);
        pulse = 1'b0;
        tick(2);
        check("upwrap_once", 32'(wrap_cnt - w0), 32'd1);

        // Down wrap and borrow ripple.
        do_clear();
        check("clear_count", 32'(count0), 32'h0);
        up_down = 1'b0;
        pulse   = 1'b1;
        tick(1);
        check("dnwrap_count", 32'(count0), 32'h9999);
        check("dnwrap_wrap",  32'(wrap0),  32'h1);
        tick(1);
        check("dnwrap_wrap_end", 32'(wrap0), 32'h0);
        pulse = 1'b0;
        tick(2);
        do_load(16'h0100);
        pulse_once(1'b0);
        check("down_0099", 32'(count0), 32'h0099);

        // Clamped load, priority, held pulse.
        do_load(16'hA3F1);
        check("clamp_load", 32'(count0), 32'h9391);
        check("load_nowrap", 32'(wrap0), 32'h0);
        clear      = 1'b1;
        load       = 1'b1;
        load_value = 16'h1234;
        up_down    = 1'b1;
        pulse      = 1'b1;
        tick(1);
        clear = 1'b0;
        load  = 1'b0;
        check("prio_clear", 32'(count0), 32'h0000);
        pulse = 1'b0;
        tick(2);
        pulse = 1'b1;
        tick(50);
        check("held_once", 32'(count0), 32'h0001);
        pulse = 1'b0;
        tick(2);
        check("held_after", 32'(count0), 32'h0001);

        // Display scan of 0042.
        do_load(16'h0042);
        tick(2);
        n = 0;
        while (en0 == 4'hE && n < 40) begin tick(1); n++; end
        while (en0 != 4'hE && n < 40) begin tick(1); n++; end
        check("scan_sync", 32'(en0), 32'hE);
        for (int d = 0; d < 4; d++) begin
            for (int c = 0; c < DIV; c++) begin
                check("scan_enable",  32'(en0),   32'(exp_en[d]));
                check("scan_data",    32'(data0), 32'(exp_d0[d]));
                check("scan_data_lz", 32'(data1), 32'(exp_d1[d]));
                tick(1);
            end
        end

        // Reset mid-refresh with pulse rising in the same cycle.
        tick(2);
        rst     = 1'b1;
        up_down = 1'b1;
        pulse   = 1'b1;
        tick(1);
        check("midrst_count",  32'(count0), 32'h0);
        check("midrst_enable", 32'(en0),    32'hF);
        check("midrst_data",   32'(data0),  32'hFF);
        rst = 1'b0;
        tick(1);
        check("midrst_first_enable", 32'(en0),    32'hE);
        check("midrst_nocount",      32'(count0), 32'h0);
        tick(5);
        check("midrst_held", 32'(count0), 32'h0);
        pulse = 1'b0;
        tick(2);
        pulse = 1'b1;
        tick(2);
        check("midrst_recount", 32'(count0), 32'h0001);
        pulse = 1'b0;
        tick(2);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
